adc_cmd_responder: RTL and testbench

- Synthesizable responder for the MAX10 modular-ADC command/response streaming interface. It is the other end from mfp_adc_max10_core: it accepts command beats, models conversion latency, and returns response beats with deterministic data.
- Used as a drop-in replacement for the vendor adc_core in simulation and in FPGA builds without ADC hardware, so controller sequencing, interrupts and free-running mode can be checked with predictable data.

---
 rtl/adc_cmd_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_adc_cmd_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cmd_responder.sv
// adc_cmd_responder: stand-in for the MAX10 modular-ADC core on its
// command/response streaming interface. Each accepted command is answered
// CONV_CYCLES clocks later by a one-cycle response beat with predictable data.
// The block holds one conversion slot and a one-entry command buffer, so a
// second command can be accepted while a conversion is running.
// Optional build macro: ADC_RESPONDER_NOISE_EN adds a 16-bit Galois LFSR whose
// low two bits are XORed into the sequence-counter data.
module adc_cmd_responder #(
    parameter int unsigned CONV_CYCLES  = 20,      // legal range 2..255
    parameter logic [11:0] TEMP_CODE    = 12'h6A5,
    parameter int unsigned TEMP_CHANNEL = 17
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        pll_locked,
    input  logic        command_valid,
    input  logic [4:0]  command_channel,
    input  logic        command_startofpacket,
    input  logic        command_endofpacket,
    output logic        command_ready,
    output logic        response_valid,
    output logic [4:0]  response_channel,
    output logic [11:0] response_data,
    output logic        response_startofpacket,
    output logic        response_endofpacket
);

    localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);
    localparam logic [4:0] TEMP_CH  = 5'(TEMP_CHANNEL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    // Conversion slot: the command currently being converted.
    logic [4:0]  slot_ch_q;
    logic        slot_sop_q, slot_eop_q;

    // One-entry buffer for a command accepted during a conversion.
    logic [4:0]  buf_ch_q;
    logic        buf_sop_q, buf_eop_q;
    logic        buf_full_q;

    logic [6:0]  seq_cnt_q;
    logic        run_q;

    logic        accept;
    logic        load_slot_cmd, load_slot_buf, load_buf, clr_buf;
    logic        resp_start;
    logic        slot_is_seq;
    logic [11:0] resp_data_d;

`ifdef ADC_RESPONDER_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
`endif

    // run_q keeps command_ready low while reset is held and for the
    // first edge after release.
    assign command_ready = pll_locked && run_q && !buf_full_q;
    assign accept        = command_valid && command_ready;
    assign resp_start    = (state_q == CONV) && (cnt_q == 8'd0);
    assign slot_is_seq   = (slot_ch_q < TEMP_CH);

    // Reset-release flag that gates command acceptance.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            // NOTE: every clocked register uses <= so all flops update from
            // the same pre-edge values; = here would create ordering races.
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // FSM state and conversion-countdown register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and slot/buffer load controls.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d       = state_q;
        cnt_d         = cnt_q;
        load_slot_cmd = 1'b0;
        load_slot_buf = 1'b0;
        load_buf      = 1'b0;
        clr_buf       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = CONV;
                    cnt_d         = CNT_LOAD;
                    load_slot_cmd = 1'b1;
                end
            end
            CONV: begin
                // command_ready is low while the buffer is full, so an
                // accept here always finds the buffer empty.
                if (accept) begin
                    load_buf = 1'b1;
                end
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (buf_full_q) begin
                    state_d       = CONV;
                    cnt_d         = CNT_LOAD;
                    load_slot_buf = 1'b1;
                    clr_buf       = 1'b1;
                end else if (accept) begin
                    state_d       = CONV;
                    cnt_d         = CNT_LOAD;
                    load_slot_cmd = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Conversion slot and command buffer storage.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            slot_ch_q  <= 5'd0;
            slot_sop_q <= 1'b0;
            slot_eop_q <= 1'b0;
            buf_ch_q   <= 5'd0;
            buf_sop_q  <= 1'b0;
            buf_eop_q  <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            if (load_slot_cmd) begin
                slot_ch_q  <= command_channel;
                slot_sop_q <= command_startofpacket;
                slot_eop_q <= command_endofpacket;
            end else if (load_slot_buf) begin
                slot_ch_q  <= buf_ch_q;
                slot_sop_q <= buf_sop_q;
                slot_eop_q <= buf_eop_q;
            end
            if (load_buf) begin
                buf_ch_q   <= command_channel;
                buf_sop_q  <= command_startofpacket;
                buf_eop_q  <= command_endofpacket;
                buf_full_q <= 1'b1;
            end else if (clr_buf) begin
                buf_full_q <= 1'b0;
            end
        end
    end

`ifdef ADC_RESPONDER_NOISE_EN
    // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running every clock.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Response data for the channel in the conversion slot. With noise
    // enabled, lfsr_d is the LFSR value visible during the RESP cycle.
    always_comb begin
        resp_data_d = {slot_ch_q, seq_cnt_q};
        if (slot_ch_q == TEMP_CH) begin
            resp_data_d = TEMP_CODE;
        end else if (slot_ch_q > TEMP_CH) begin
            resp_data_d = 12'h000;
        end else begin
`ifdef ADC_RESPONDER_NOISE_EN
            resp_data_d[1:0] = seq_cnt_q[1:0] ^ lfsr_d[1:0];
`else
            resp_data_d[1:0] = seq_cnt_q[1:0];
`endif
        end
    end

    // Sequence counter advances after each RESP for ordinary channels.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            seq_cnt_q <= 7'd0;
        end else if ((state_q == RESP) && slot_is_seq) begin
            seq_cnt_q <= seq_cnt_q + 7'd1;
        end
    end

    // Response beat registers; fields hold between beats.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            response_valid         <= 1'b0;
            response_channel       <= 5'd0;
            response_data          <= 12'h000;
            response_startofpacket <= 1'b0;
            response_endofpacket   <= 1'b0;
        end else begin
            response_valid <= resp_start;
            if (resp_start) begin
                response_channel       <= slot_ch_q;
                response_data          <= resp_data_d;
                response_startofpacket <= slot_sop_q;
                response_endofpacket   <= slot_eop_q;
            end
        end
    end

endmodule

// File: tb/tb_adc_cmd_responder.sv
// Directed self-checking bench for adc_cmd_responder (default build,
// CONV_CYCLES = 20, TEMP_CHANNEL = 17, TEMP_CODE = 12'h6A5).
module tb_adc_cmd_responder;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        pll_locked;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  ch;
        logic [11:0] data;
        logic        sop;
        logic        eop;
    } resp_t;

    resp_t resp_q[$];

    adc_cmd_responder #(
        .CONV_CYCLES (20),
        .TEMP_CODE   (12'h6A5),
        .TEMP_CHANNEL(17)
    ) dut (
        .CLK                   (CLK),
        .RESETn                (RESETn),
        .pll_locked            (pll_locked),
        .command_valid         (command_valid),
        .command_channel       (command_channel),
        .command_startofpacket (command_startofpacket),
        .command_endofpacket   (command_endofpacket),
        .command_ready         (command_ready),
        .response_valid        (response_valid),
        .response_channel      (response_channel),
        .response_data         (response_data),
        .response_startofpacket(response_startofpacket),
        .response_endofpacket  (response_endofpacket)
    );

    always #5 CLK = ~CLK;

    // Edge counter: between posedge k and posedge k+1, cyc == k.
    always @(posedge CLK) cyc <= cyc + 1;

    // Response monitor, sampled 1 time unit after each rising edge.
    always begin : mon
        resp_t r;
        @(posedge CLK);
        #1;
        if (response_valid === 1'b1) begin
            r.cyc  = cyc;
            r.ch   = response_channel;
            r.data = response_data;
            r.sop  = response_startofpacket;
            r.eop  = response_endofpacket;
            resp_q.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command from a negedge; returns the edge number of
    // acceptance and leaves the bench at the negedge after that edge.
    task automatic send(input logic [4:0] ch, input logic sop, input logic eop,
                        output int unsigned acc);
        int n = 0;
        command_valid         = 1'b1;
        command_channel       = ch;
        command_startofpacket = sop;
        command_endofpacket   = eop;
        while (command_ready !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("accept_wait", 32'(command_ready), 32'd1);
        acc = cyc + 1;
        @(negedge CLK);
        command_valid = 1'b0;
    endtask

    // Wait (bounded) until at least n responses have been captured.
    task automatic wait_resp(input int n, input int budget, input string tag);
        int k = 0;
        while (resp_q.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(tag, 32'(resp_q.size()), 32'(n));
    endtask

    initial begin : stim
        int unsigned acc, acc2, acc3, acc4;
        int          bad;

        // ---------------- reset, then PLL lock ----------------
        RESETn                = 1'b0;
        pll_locked            = 1'b0;
        command_valid         = 1'b1;
        command_channel       = 5'd9;
        command_startofpacket = 1'b1;
        command_endofpacket   = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(command_ready), 32'd0);
        check("rst_valid", 32'(response_valid), 32'd0);
        check("rst_chan",  32'(response_channel), 32'd0);
        check("rst_data",  32'(response_data), 32'd0);
        check("rst_sop",   32'(response_startofpacket), 32'd0);
        check("rst_eop",   32'(response_endofpacket), 32'd0);
        RESETn = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge CLK);
            if (command_ready !== 1'b0) bad++;
        end
        check("unlocked_ready_cycles", 32'(bad), 32'd0);
        check("unlocked_no_resp", 32'(resp_q.size()), 32'd0);
        command_valid = 1'b0;
        pll_locked    = 1'b1;
        @(negedge CLK);
        check("locked_ready", 32'(command_ready), 32'd1);

        // ---------------- single command, channel 1 ----------------
        send(5'd1, 1'b1, 1'b1, acc);
        wait_resp(1, 40, "single_count");
        if (resp_q.size() >= 1) begin
            check("single_latency", resp_q[0].cyc - acc, 32'd20);
            check("single_chan", 32'(resp_q[0].ch), 32'd1);
            check("single_data", 32'(resp_q[0].data), 32'h080);
            check("single_sop",  32'(resp_q[0].sop), 32'd1);
            check("single_eop",  32'(resp_q[0].eop), 32'd1);
        end
        repeat (3) @(negedge CLK);
        check("single_one_pulse", 32'(resp_q.size()), 32'd1);
        check("hold_valid_low", 32'(response_valid), 32'd0);
        check("hold_data", 32'(response_data), 32'h080);
        check("hold_chan", 32'(response_channel), 32'd1);
        resp_q.delete();

        // ---------------- back-to-back 2,3 then stalled third beat ----------------
        send(5'd2, 1'b1, 1'b0, acc2);
        send(5'd3, 1'b0, 1'b1, acc3);
        check("b2b_second_accept", acc3 - acc2, 32'd1);
        command_valid         = 1'b1;
        command_channel       = 5'd4;
        command_startofpacket = 1'b1;
        command_endofpacket   = 1'b1;
        check("b2b_third_stall", 32'(command_ready), 32'd0);
        send(5'd4, 1'b1, 1'b1, acc4);
        check("b2b_third_accept", acc4 - acc2, 32'd22);
        wait_resp(3, 100, "b2b_count");
        if (resp_q.size() >= 3) begin
            check("b2b_r0_data", 32'(resp_q[0].data), 32'h101);
            check("b2b_r0_chan", 32'(resp_q[0].ch), 32'd2);
            check("b2b_r0_sop",  32'(resp_q[0].sop), 32'd1);
            check("b2b_r0_eop",  32'(resp_q[0].eop), 32'd0);
            check("b2b_r0_latency", resp_q[0].cyc - acc2, 32'd20);
            check("b2b_r1_data", 32'(resp_q[1].data), 32'h182);
            check("b2b_r1_sop",  32'(resp_q[1].sop), 32'd0);
            check("b2b_r1_eop",  32'(resp_q[1].eop), 32'd1);
            check("b2b_r1_gap",  resp_q[1].cyc - resp_q[0].cyc, 32'd21);
            check("b2b_r2_data", 32'(resp_q[2].data), 32'h203);
            check("b2b_r2_gap",  resp_q[2].cyc - resp_q[1].cyc, 32'd21);
        end
        resp_q.delete();

        // ---------------- temperature and out-of-range channels ----------------
        send(5'd17, 1'b1, 1'b1, acc);
        wait_resp(1, 40, "temp_count");
        if (resp_q.size() >= 1) begin
            check("temp_data", 32'(resp_q[0].data), 32'h6A5);
            check("temp_chan", 32'(resp_q[0].ch), 32'd17);
        end
        resp_q.delete();
        send(5'd20, 1'b1, 1'b1, acc);
        wait_resp(1, 40, "zero_count");
        if (resp_q.size() >= 1) begin
            check("zero_data", 32'(resp_q[0].data), 32'h000);
            check("zero_chan", 32'(resp_q[0].ch), 32'd20);
        end
        resp_q.delete();
        // seq_cnt is still 4 (channels 1,2,3,4 only): {5'd5, 7'd4}.
        send(5'd5, 1'b1, 1'b1, acc);
        wait_resp(1, 40, "seq_hold_count");
        if (resp_q.size() >= 1) begin
            check("seq_hold_data", 32'(resp_q[0].data), 32'h284);
        end
        resp_q.delete();

        // ---------------- reset during CONV with buffer full ----------------
        send(5'd6, 1'b1, 1'b0, acc);
        send(5'd7, 1'b0, 1'b1, acc);
        check("rstmid_buf_full_ready", 32'(command_ready), 32'd0);
        repeat (8) @(negedge CLK);
        RESETn = 1'b0;
        #1;
        check("rstmid_ready", 32'(command_ready), 32'd0);
        check("rstmid_valid", 32'(response_valid), 32'd0);
        repeat (3) @(negedge CLK);
        check("rstmid_ready_held", 32'(command_ready), 32'd0);
        RESETn = 1'b1;
        repeat (40) @(negedge CLK);
        check("rstmid_no_resp", 32'(resp_q.size()), 32'd0);
        send(5'd8, 1'b1, 1'b1, acc);
        wait_resp(1, 40, "rstmid_after_count");
        if (resp_q.size() >= 1) begin
            check("rstmid_after_data", 32'(resp_q[0].data), 32'h400);
        end
        resp_q.delete();

        // ---------------- 130 conversions on channel 0: seq_cnt wrap ----------------
        RESETn = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        resp_q.delete();
        for (int i = 0; i < 130; i++) begin
            send(5'd0, 1'b1, 1'b1, acc);
            wait_resp(1, 40, "wrap_count");
            if (resp_q.size() >= 1) begin
                check("wrap_data", 32'(resp_q[0].data), 32'(i % 128));
            end
            resp_q.delete();
        end

        repeat (5) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
